// File: rtl/irq_pending_latch_if.sv
// irq_pending_latch_if: request/mask/encoder/handshake bundle for irq_pending_latch.
// The master side is the environment: request lines, mask, encoder result and consumer ack.
// The slave side is the latch itself.
interface irq_pending_latch_if #(
  parameter int N    = 8,
  parameter int ID_W = 3
);
  logic [N-1:0]    req_in;
  logic [N-1:0]    mask_in;
  logic [N-1:0]    pend_x;
  logic [ID_W-1:0] enc_y;
  logic            enc_valid;
  logic            irq_out;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;
  logic [N-1:0]    pending;

  modport master (
    output req_in, mask_in, enc_y, enc_valid, irq_ack,
    input  pend_x, irq_out, irq_id, pending
  );

  modport slave (
    input  req_in, mask_in, enc_y, enc_valid, irq_ack,
    output pend_x, irq_out, irq_id, pending
  );
endinterface

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: captures rising edges on the request lines into sticky
// pending bits, feeds the masked vector to an external priority encoder and
// presents one interrupt at a time over an irq/ack handshake.
// Optional feature macro: IRQ_SYNC_EN adds a two-flop synchronizer on req_in
// (4-edge request-to-irq latency); without it req_in is captured by a single
// flop (3-edge latency) and must already be synchronous to clk.
module irq_pending_latch #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input logic                 clk,
  input logic                 rst,
  irq_pending_latch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GUARD  = 2'd2
  } state_t;

  logic [N-1:0]    s2;
  logic [N-1:0]    s3;
  logic [N-1:0]    edge_p;
  logic [N-1:0]    pend_q;
  logic [N-1:0]    clr;
  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_next;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] s1;

  // Two-flop synchronizer for the asynchronous request lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.req_in;
      s2 <= s1;
    end
  end
`else
  // Single capture flop; req_in is assumed synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      s2 <= bus.req_in;
    end
  end
`endif

  // History flop for edge detection; reset to 0 so a line high at release counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3 <= '0;
    end else begin
      s3 <= s2;
    end
  end

  assign edge_p = s2 & ~s3;

  // Sticky pending bits: a fresh edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | edge_p;
    end
  end

  // FSM state and latched interrupt index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_next;
      id_q  <= id_next;
    end
  end

  // Next-state, index capture and the ack-driven pending clear.
  always_comb begin
    state_next = state;
    id_next    = id_q;
    clr        = '0;
    unique case (state)
      IDLE: begin
        if (bus.enc_valid) begin
          id_next    = bus.enc_y;
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.irq_ack) begin
          clr        = {{(N-1){1'b0}}, 1'b1} << id_q;
          state_next = GUARD;
        end
      end
      GUARD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.pending = pend_q;
  assign bus.pend_x  = pend_q & bus.mask_in;
  assign bus.irq_out = (state == ASSERT);
  assign bus.irq_id  = id_q;

endmodule
